chan_link_ctrl: RTL

- Per-channel Aurora link bring-up and supervision controller, clocked on the programming clock alongside the channel I/O register block.
- Sequences GT and Aurora resets, waits for PLL lock, reset-done and channel_up, and times out and retries on failure.
- Drops and re-establishes the link on hard errors.
- Exposes state, retry count and saturating error counters for the channel status registers to read back.

---
 rtl/chan_link_pkg.sv | 35 +++
 rtl/sat_counter.sv | 20 ++
 rtl/chan_link_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/chan_link_pkg.sv
// Shared widths, state encoding and status payload for the Aurora channel link controller.
package chan_link_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_GT_RST    = 3'd1,
    ST_AUR_RST   = 3'd2,
    ST_WAIT_PLL  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WAIT_CHAN = 3'd5,
    ST_UP        = 3'd6,
    ST_FAILED    = 3'd7
  } link_state_e;

  // GT/Aurora status flags, carried together through the synchronizer
  typedef struct packed {
    logic pll_not_locked;
    logic tx_resetdone;
    logic rx_resetdone;
    logic lane_up;
    logic channel_up;
    logic hard_err;
    logic soft_err;
    logic frame_err;
  } link_status_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         io_clk,
  input  logic         io_reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge io_clk) begin
    if (io_reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/chan_link_ctrl.sv
// Per-channel Aurora link bring-up and supervision controller.
// Error counters are built only when CHAN_LINK_CTRL_ERRCNT_EN is defined; otherwise they read 0.
module chan_link_ctrl
  import chan_link_pkg::*;
#(
  parameter int unsigned GT_RST_CYCLES  = 128,
  parameter int unsigned AUR_RST_CYCLES = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 15
) (
  input  logic               io_clk,
  input  logic               io_reset,
  input  logic               enable,
  input  logic               force_reset,
  input  logic               err_clear,
  input  logic               pll_not_locked,
  input  logic               tx_resetdone_out,
  input  logic               rx_resetdone_out,
  input  logic               lane_up,
  input  logic               channel_up,
  input  logic               hard_err,
  input  logic               soft_err,
  input  logic               frame_err,
  output logic               gt_reset,
  output logic               aurora_reset,
  output logic               link_ok,
  output logic               link_failed,
  output logic [STATE_W-1:0] state_out,
  output logic [RETRY_W-1:0] retry_count,
  output logic [CNT_W-1:0]   hard_err_cnt,
  output logic [CNT_W-1:0]   soft_err_cnt,
  output logic [CNT_W-1:0]   frame_err_cnt
);

`ifdef CHAN_LINK_CTRL_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  localparam int unsigned TMR_W =
    $clog2(max_u(TIMEOUT_CYCLES, max_u(GT_RST_CYCLES, AUR_RST_CYCLES)) + 1);
  localparam logic [TMR_W-1:0] GT_LAST  = TMR_W'(GT_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] AUR_LAST = TMR_W'(AUR_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  link_status_t stat_raw, stat_meta, stat_sync;
  link_state_e  state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic retry_req, restart, retry_exhausted;
  logic gt_reset_nxt, aurora_reset_nxt, link_ok_nxt, link_failed_nxt;

  assign stat_raw = {pll_not_locked, tx_resetdone_out, rx_resetdone_out,
                     lane_up, channel_up, hard_err, soft_err, frame_err};

  // Two-flop synchronizer for all GT/Aurora status inputs
  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      stat_meta <= '0;
      stat_sync <= '0;
    end else begin
      stat_meta <= stat_raw;
      stat_sync <= stat_meta;
    end
  end

  assign retry_exhausted = (retry_count >= RETRY_W'(MAX_RETRIES));

  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    retry_req = 1'b0;
    restart   = 1'b0;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_GT_RST;
      ST_GT_RST: begin
        timer_nxt = timer + TMR_W'(1);
        if (timer == GT_LAST) state_nxt = ST_AUR_RST;
      end
      ST_AUR_RST: begin
        timer_nxt = timer + TMR_W'(1);
        if (timer == AUR_LAST) state_nxt = ST_WAIT_PLL;
      end
      ST_WAIT_PLL: begin
        timer_nxt = timer + TMR_W'(1);
        if (!stat_sync.pll_not_locked) state_nxt = ST_WAIT_DONE;
        else if (timer == TO_LAST)     retry_req = 1'b1;
      end
      ST_WAIT_DONE: begin
        timer_nxt = timer + TMR_W'(1);
        if (stat_sync.tx_resetdone && stat_sync.rx_resetdone) state_nxt = ST_WAIT_CHAN;
        else if (timer == TO_LAST)                            retry_req = 1'b1;
      end
      ST_WAIT_CHAN: begin
        timer_nxt = timer + TMR_W'(1);
        if (stat_sync.lane_up && stat_sync.channel_up) state_nxt = ST_UP;
        else if (timer == TO_LAST)                     retry_req = 1'b1;
      end
      ST_UP:     if (stat_sync.hard_err || !stat_sync.channel_up) retry_req = 1'b1;
      ST_FAILED: state_nxt = ST_FAILED;
      default:   state_nxt = ST_IDLE;
    endcase

    if (retry_req) state_nxt = retry_exhausted ? ST_FAILED : ST_GT_RST;
    // Manual restart and disable override supervision, neither counts as a retry
    if (force_reset && (state != ST_IDLE)) begin
      restart   = 1'b1;
      retry_req = 1'b0;
      state_nxt = ST_GT_RST;
    end
    if (!enable) begin
      restart   = 1'b0;
      retry_req = 1'b0;
      state_nxt = ST_IDLE;
    end
    if ((state_nxt != state) || restart) timer_nxt = '0;

    gt_reset_nxt     = (state_nxt == ST_IDLE) || (state_nxt == ST_GT_RST) ||
                       (state_nxt == ST_FAILED);
    aurora_reset_nxt = gt_reset_nxt || (state_nxt == ST_AUR_RST);
    link_ok_nxt      = (state_nxt == ST_UP);
    link_failed_nxt  = (state_nxt == ST_FAILED);
  end

  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      gt_reset     <= 1'b1;
      aurora_reset <= 1'b1;
      link_ok      <= 1'b0;
      link_failed  <= 1'b0;
      retry_count  <= '0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      gt_reset     <= gt_reset_nxt;
      aurora_reset <= aurora_reset_nxt;
      link_ok      <= link_ok_nxt;
      link_failed  <= link_failed_nxt;
      if (err_clear)                          retry_count <= '0;
      else if (retry_req && !retry_exhausted) retry_count <= retry_count + RETRY_W'(1);
    end
  end

  assign state_out = state;

  // With counters disabled the instances are held in clear and reduce to constant zero
  sat_counter #(.W(CNT_W)) u_hard_cnt (
    .io_clk   (io_clk),
    .io_reset (io_reset),
    .inc      (ERRCNT_EN && stat_sync.hard_err),
    .clr      (err_clear || !ERRCNT_EN),
    .count    (hard_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_soft_cnt (
    .io_clk   (io_clk),
    .io_reset (io_reset),
    .inc      (ERRCNT_EN && stat_sync.soft_err),
    .clr      (err_clear || !ERRCNT_EN),
    .count    (soft_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .io_clk   (io_clk),
    .io_reset (io_reset),
    .inc      (ERRCNT_EN && stat_sync.frame_err),
    .clr      (err_clear || !ERRCNT_EN),
    .count    (frame_err_cnt)
  );

endmodule
